// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: control bundle, MemtoReg encoding, load funct3 codes.
package wb_pkg;

    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_PC  = 2'd2,
        MTR_IMM = 2'd3
    } mtr_e;

    typedef struct packed {
        logic RegWrite;
        mtr_e MemtoReg;
        logic Jump;
    } wb_control_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for buffered late writes; exposes per-slot contents and occupancy
// so the owner can summarise what is still in flight.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       din,
    output logic [W-1:0]       dout,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count,
    output logic [PW-1:0]      head,
    output logic [DEPTH-1:0]   valid,
    output logic [DEPTH*W-1:0] entries
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_comb begin
        logic [PW-1:0] off;
        valid   = '0;
        entries = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off                 = PW'(i) - rd_ptr;
            valid[i]            = ({1'b0, off} < count);
            entries[i*W +: W]   = mem[i];
        end
    end

    assign dout  = mem[rd_ptr];
    assign head  = rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline writes win, late results bypass or queue for idle slots.
// Define WB_LOAD_ALIGN_EN to enable byte/halfword load alignment and extension.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   pc_offset,
    input  logic [XLEN-1:0]   pc_incr,
    input  logic [XLEN-1:0]   immediate,
    input  logic [XLEN-1:0]   data_in,
    input  wb_control_t       wb_ctrl,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic [AW-1:0]     rd_addr_in,
    input  logic              lr_valid,
    output logic              lr_ready,
    input  logic [AW-1:0]     lr_rd,
    input  logic [XLEN-1:0]   lr_data,
    output logic              RegWrite,
    output logic [AW-1:0]     rd_addr_out,
    output logic [XLEN-1:0]   rd_data,
    output logic [2**AW-1:0]  pending_mask,
    output logic              fifo_full
);

    localparam int EW = AW + XLEN;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0]     load_val;
    logic [XLEN-1:0]     pipe_val;
    logic                pipe_active, slot_free, accept, bypass, push, pop;
    logic                full, empty;
    logic [CW-1:0]       fifo_count;
    logic [PW-1:0]       head;
    logic [DEPTH-1:0]    valid;
    logic [DEPTH*EW-1:0] entries;
    logic [EW-1:0]       head_entry;
    logic [2**AW-1:0]    mask_next;

`ifdef WB_LOAD_ALIGN_EN
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = data_in >> {ld_addr_lo, 3'b000};
        case (ld_funct3)
            F3_LB:   load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_val = data_in;
        endcase
    end
`else
    logic unused_ld;
    assign unused_ld = ^{ld_funct3, ld_addr_lo};
    assign load_val  = data_in;
`endif

    always_comb begin
        case (wb_ctrl.MemtoReg)
            MTR_ALU: pipe_val = alu_result;
            MTR_MEM: pipe_val = load_val;
            MTR_PC:  pipe_val = wb_ctrl.Jump ? pc_incr : pc_offset;
            default: pipe_val = immediate;
        endcase
    end

    // A full FIFO can still take a late result when the head drains in the same cycle.
    assign pipe_active = !rst && wb_ctrl.RegWrite && (rd_addr_in != '0);
    assign slot_free   = !pipe_active;
    assign lr_ready    = !rst && (!full || (slot_free && fifo_count == FULL_CNT));
    assign accept      = lr_valid && lr_ready;
    assign pop         = !rst && slot_free && !empty;
    assign bypass      = slot_free && empty && accept && (lr_rd != '0);
    assign push        = accept && (lr_rd != '0) && !bypass;
    assign fifo_full   = full && !rst;

    wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     ({lr_rd, lr_data}),
        .dout    (head_entry),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count),
        .head    (head),
        .valid   (valid),
        .entries (entries)
    );

    always_comb begin
        RegWrite    = 1'b0;
        rd_addr_out = '0;
        rd_data     = '0;
        if (pipe_active) begin
            RegWrite    = 1'b1;
            rd_addr_out = rd_addr_in;
            rd_data     = pipe_val;
        end else if (pop) begin
            RegWrite    = 1'b1;
            rd_addr_out = head_entry[XLEN +: AW];
            rd_data     = head_entry[XLEN-1:0];
        end else if (bypass) begin
            RegWrite    = 1'b1;
            rd_addr_out = lr_rd;
            rd_data     = lr_data;
        end
    end

    // Mask tracks the FIFO contents as they will be after this edge.
    always_comb begin
        mask_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && !(pop && PW'(i) == head))
                mask_next[entries[i*EW+XLEN +: AW]] = 1'b1;
        end
        if (push) mask_next[lr_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_mask <= '0;
        else     pending_mask <= mask_next;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, pc_offset, pc_incr, immediate, data_in, lr_data;
    wb_control_t wb_ctrl;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [4:0]  rd_addr_in, lr_rd, rd_addr_out;
    logic        lr_valid, lr_ready, RegWrite, fifo_full;
    logic [31:0] rd_data, pending_mask;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;
    entry_t q[$];

    wb_arbiter #(.XLEN(32), .AW(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .pc_offset(pc_offset),
        .pc_incr(pc_incr), .immediate(immediate), .data_in(data_in), .wb_ctrl(wb_ctrl),
        .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .rd_addr_in(rd_addr_in),
        .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_rd(lr_rd), .lr_data(lr_data),
        .RegWrite(RegWrite), .rd_addr_out(rd_addr_out), .rd_data(rd_data),
        .pending_mask(pending_mask), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_exp(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] off);
`ifdef WB_LOAD_ALIGN_EN
        logic [31:0] s;
        logic signed [7:0] sb;
        logic signed [15:0] sh;
        int v;
        s  = d >> (off * 8);
        sb = s[7:0];
        sh = s[15:0];
        case (f3)
            F3_LB:   begin v = sb; return v; end
            F3_LH:   begin v = sh; return v; end
            F3_LBU:  return s & 32'hFF;
            F3_LHU:  return s & 32'hFFFF;
            default: return d;
        endcase
`else
        if (f3 == 3'b111 && off == 2'd3) return d;
        return d;
`endif
    endfunction

    function automatic logic [31:0] pipe_exp();
        case (wb_ctrl.MemtoReg)
            MTR_ALU: return alu_result;
            MTR_MEM: return load_exp(data_in, ld_funct3, ld_addr_lo);
            MTR_PC:  return wb_ctrl.Jump ? pc_incr : pc_offset;
            default: return immediate;
        endcase
    endfunction

    // One clock cycle: predict, compare before the edge, then advance the model at the edge.
    task automatic step();
        logic        exp_we, exp_rdy, exp_full, pa, acc, do_pop, do_push;
        logic [4:0]  exp_rd;
        logic [31:0] exp_d, exp_mask;
        entry_t      e;
        exp_mask = '0;
        foreach (q[i]) exp_mask[q[i].rd] = 1'b1;
        exp_we = 0; exp_rd = 0; exp_d = 0; do_pop = 0; do_push = 0;
        if (rst) begin
            exp_rdy = 0; exp_full = 0;
        end else begin
            pa       = wb_ctrl.RegWrite && rd_addr_in != 0;
            exp_full = (q.size() == 4);
            exp_rdy  = !exp_full || !pa;
            acc      = lr_valid && exp_rdy;
            if (pa) begin
                exp_we = 1; exp_rd = rd_addr_in; exp_d = pipe_exp();
                do_push = acc && lr_rd != 0;
            end else if (q.size() > 0) begin
                exp_we = 1; exp_rd = q[0].rd; exp_d = q[0].data;
                do_pop = 1;
                do_push = acc && lr_rd != 0;
            end else if (acc && lr_rd != 0) begin
                exp_we = 1; exp_rd = lr_rd; exp_d = lr_data;
            end
        end
        @(negedge clk);
        check_eq("regwrite", RegWrite, exp_we);
        check_eq("rd_addr_out", rd_addr_out, exp_rd);
        check_eq("rd_data", rd_data, exp_d);
        check_eq("lr_ready", lr_ready, exp_rdy);
        check_eq("fifo_full", fifo_full, exp_full);
        check_eq("pending_mask", pending_mask, exp_mask);
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.rd = lr_rd; e.data = lr_data;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; wb_ctrl = '0; rd_addr_in = 0; lr_valid = 0; lr_rd = 0; lr_data = 0;
        alu_result = 32'h11; pc_offset = 32'h22; pc_incr = 32'h33; immediate = 32'h44;
        data_in = 32'h55; ld_funct3 = F3_LW; ld_addr_lo = 0;
    endtask

    task automatic pipe_wr(input logic [4:0] rd, input mtr_e m, input logic j);
        wb_ctrl.RegWrite = 1; wb_ctrl.MemtoReg = m; wb_ctrl.Jump = j; rd_addr_in = rd;
    endtask

    logic [2:0] f3_tab [5];

    initial begin
        f3_tab[0] = F3_LB; f3_tab[1] = F3_LH; f3_tab[2] = F3_LW;
        f3_tab[3] = F3_LBU; f3_tab[4] = F3_LHU;
        idle();
        rst = 1;
        @(posedge clk); #1;
        step();                       // reset state
        idle();

        // Jump/branch target select
        pipe_wr(5, MTR_PC, 1); pc_incr = 32'h104; #1;
        check_eq("jal_we", RegWrite, 1); check_eq("jal_rd", rd_addr_out, 5);
        check_eq("jal_data", rd_data, 32'h104);
        step();
        wb_ctrl.Jump = 0; pc_offset = 32'h2000; #1;
        check_eq("br_data", rd_data, 32'h2000);
        step();

        // Load path
        pipe_wr(1, MTR_MEM, 0); data_in = 32'h80FF7F01; ld_funct3 = F3_LB; ld_addr_lo = 3; #1;
`ifdef WB_LOAD_ALIGN_EN
        check_eq("lb_off3", rd_data, 32'hFFFFFF80);
`else
        check_eq("load_raw", rd_data, 32'h80FF7F01);
`endif
        step();
        ld_funct3 = F3_LHU; ld_addr_lo = 2; #1;
`ifdef WB_LOAD_ALIGN_EN
        check_eq("lhu_off2", rd_data, 32'h000080FF);
`else
        check_eq("load_raw2", rd_data, 32'h80FF7F01);
`endif
        step();

        // Fill the FIFO behind a busy pipeline
        idle();
        pipe_wr(3, MTR_ALU, 0);
        for (int i = 0; i < 4; i++) begin
            lr_valid = 1; lr_rd = 5'(8 + i); lr_data = 32'hA000 + i;
            step();
        end
        lr_rd = 12; lr_data = 32'hA004; #1;
        check_eq("full_flag", fifo_full, 1); check_eq("full_blocks", lr_ready, 0);
        check_eq("full_pipe_rd", rd_addr_out, 3);
        step();
        // Full and idle: pop and push together
        wb_ctrl = '0; #1;
        check_eq("full_idle_ready", lr_ready, 1);
        step();
        check_eq("full_after_swap", fifo_full, 1);
        lr_valid = 0;
        for (int i = 0; i < 4; i++) step();
        check_eq("drained_mask", pending_mask, 0);

        // Bypass into an empty FIFO
        lr_valid = 1; lr_rd = 7; lr_data = 32'hDEADBEEF; #1;
        check_eq("bypass_rd", rd_addr_out, 7); check_eq("bypass_data", rd_data, 32'hDEADBEEF);
        step();
        lr_valid = 0;
        step();
        check_eq("bypass_no_queue", pending_mask, 0);

        // Reset discards buffered entries
        pipe_wr(3, MTR_IMM, 0);
        for (int i = 0; i < 3; i++) begin
            lr_valid = 1; lr_rd = 5'(20 + i); lr_data = 32'hB000 + i;
            step();
        end
        rst = 1; step();
        rst = 0; wb_ctrl = '0; lr_valid = 1; lr_rd = 9; lr_data = 32'hC0DE; #1;
        check_eq("post_rst_mask", pending_mask, 0);
        check_eq("post_rst_ready", lr_ready, 1);
        check_eq("post_rst_rd", rd_addr_out, 9);
        step();
        idle();
        step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst              = ($urandom_range(0, 49) == 0);
            wb_ctrl.RegWrite = $urandom_range(0, 1);
            wb_ctrl.MemtoReg = mtr_e'($urandom_range(0, 3));
            wb_ctrl.Jump     = $urandom_range(0, 1);
            rd_addr_in       = 5'($urandom_range(0, 7));
            alu_result = $urandom; pc_offset = $urandom; pc_incr = $urandom;
            immediate  = $urandom; data_in   = $urandom;
            ld_funct3  = f3_tab[$urandom_range(0, 4)];
            ld_addr_lo = 2'($urandom_range(0, 3));
            lr_valid   = ($urandom_range(0, 9) < 6);
            lr_rd      = 5'($urandom_range(0, 15));
            lr_data    = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, data width.
- AW, 5, register address width.
- DEPTH, 4, late-result FIFO entries (power of two, >=2).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock. One clock; reset is synchronous and active-high.
- rst, in, 1, synchronous, active-high reset.
- alu_result, pc_offset, pc_incr, immediate, data_in, in, XLEN, pipeline writeback sources.
- wb_ctrl, in, wb_control_t, pipeline writeback control: RegWrite, MemtoReg[1:0], Jump.
- ld_funct3, in, 3, load type.
- ld_addr_lo, in, 2, load byte offset.
- rd_addr_in, in, AW, pipeline destination register.
- lr_valid, in, 1, late result offered by a multicycle unit.
- lr_ready, out, 1, late result accepted.
- lr_rd, in, AW, late result destination.
- lr_data, in, XLEN, late result value.
- RegWrite, out, 1, register file write enable.
- rd_addr_out, out, AW, write address.
- rd_data, out, XLEN, write data.
- pending_mask, out, 2**AW, one bit per register with a buffered late write.
- fifo_full, out, 1, FIFO holds DEPTH entries.

Function
REQ-003 Pipeline select: MemtoReg 0 selects alu_result; 1 selects the load value; 2 selects pc_incr if Jump=1, else pc_offset; 3 selects immediate.
REQ-004 A pipeline write is active when wb_ctrl.RegWrite=1 and rd_addr_in!=0. An active pipeline write drives the outputs combinationally in the same cycle, with zero latency.
REQ-005 The pipeline has absolute priority and is never back-pressured.
REQ-006 Late results are accepted when lr_valid && lr_ready. lr_ready = !fifo_full || (slot_free && fifo_count == DEPTH). slot_free = no active pipeline write.
REQ-007 Late result with lr_rd=0: accepted, then dropped. It is never enqueued and never written.
REQ-008 On a slot_free cycle with a non-empty FIFO, the head entry is written and popped, in FIFO order.
REQ-009 Bypass: on a slot_free cycle with an empty FIFO and an accepted late result, that result is written the same cycle and not enqueued.
REQ-010 Simultaneous push and pop in one cycle leaves the count unchanged. This holds when full.
REQ-011 When no write occurs, RegWrite=0, rd_addr_out=0, rd_data=0.
REQ-012 pending_mask is the OR of one-hot lr_rd over valid FIFO entries. It is registered and updates one cycle after push or pop.
REQ-013 An active pipeline write to a register with a pending buffered write does not cancel the buffered write. Program-order resolution is the scoreboard's duty via pending_mask.
REQ-014 Pointers wrap modulo DEPTH. The count is AW-independent, with width $clog2(DEPTH)+1.

Reset
REQ-015 While rst=1 at a clk edge: the FIFO is emptied, pointers and count become 0, pending_mask becomes 0.
REQ-016 During reset: lr_ready=0, RegWrite=0, fifo_full=0. Buffered entries are discarded without being written.
REQ-017 The first cycle after reset release accepts a late result.

Configuration
REQ-018 Macro WB_LOAD_ALIGN_EN, when defined, enables load alignment:
- data_in is shifted right by 8*ld_addr_lo.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-019 Without WB_LOAD_ALIGN_EN, data_in passes unmodified, and ld_funct3 and ld_addr_lo are ignored.

Structure
REQ-020 Package wb_pkg holds:
- wb_control_t;
- the MemtoReg encoding enum (MTR_ALU, MTR_MEM, MTR_PC, MTR_IMM);
- load funct3 constants.
REQ-021 The FIFO is sub-module wb_fifo, parametrised by width and DEPTH, with push/pop/full/empty/count. The arbiter contains only select, align and arbitration logic.

Verification
REQ-022 Directed scenarios:
- MemtoReg=2, Jump=1, pc_incr=0x104, rd=5 -> same cycle: RegWrite=1, rd_addr_out=5, rd_data=0x104. With Jump=0, pc_offset=0x2000 -> rd_data=0x2000.
- Pipeline writes rd=3 every cycle while 4 late results push -> fifo_full=1, lr_ready=0, no late write. The pipeline then idles 4 cycles -> entries are written in push order, and pending_mask clears bit by bit.
- Idle pipeline, empty FIFO, lr_valid with lr_rd=7, lr_data=0xDEADBEEF -> same-cycle write. FIFO count stays 0.
- FIFO full, pipeline idle, lr_valid -> lr_ready=1, simultaneous pop and push, count stays 4.
- WB_LOAD_ALIGN_EN defined, data_in=0x80FF7F01:
  - LB at offset 3 -> 0xFFFFFF80.
  - LHU at offset 2 -> 0x000080FF.
- Reset asserted with 3 entries buffered -> next cycle count=0, pending_mask=0, no write of those entries ever.
